// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes, frame field widths, default header.
// Latency: n/a (package). Backpressure: n/a.
// IMEM_LOADER_CHECKSUM_EN enables the CHK state in the loader.
package imem_loader_pkg;

    localparam int STATE_W   = 3;
    localparam int BYTE_W    = 8;
    localparam int CNT_W     = 16;
    localparam int WORD_W    = 32;
    localparam int ADDR_STEP = 4;

    localparam logic [BYTE_W-1:0] DEF_HDR_BYTE = 8'hA5;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_CNT_HI = 3'd1;
    localparam logic [STATE_W-1:0] ST_CNT_LO = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERR    = 3'd6;
    localparam logic [STATE_W-1:0] ST_CHK    = 3'd7;

    // Byte address of the next instruction word (PC-compatible stride).
    function automatic logic [WORD_W-1:0] next_addr(input logic [WORD_W-1:0] a);
        return a + WORD_W'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Big-endian word assembler: shifts bytes into a 32-bit word, flags the 4th byte combinationally.
// Latency: word/word_done valid in the same cycle as the 4th byte. Backpressure: none, follows byte_en.
module imem_loader_asm
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [WORD_W-BYTE_W-1:0] acc;
    logic [1:0]               idx;

    // The completing byte is appended live so the caller can latch the full word on the same edge.
    assign word      = {acc, byte_in};
    assign word_done = byte_en && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            idx <= '0;
        end else if (byte_en) begin
            acc <= {acc[WORD_W-2*BYTE_W-1:0], byte_in};
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame loader: HDR, 16-bit word count, big-endian words -> IMEM writes; IMEM_LOADER_CHECKSUM_EN adds XOR trailer.
// Latency: one WRITE cycle after the 4th byte of each word. Backpressure: in_ready low in WRITE and ERR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       IM_DEPTH = 256,
    parameter logic [BYTE_W-1:0] HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [WORD_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [STATE_W-1:0] ST_AFTER_DATA = ST_CHK;
`else
    localparam logic [STATE_W-1:0] ST_AFTER_DATA = ST_DONE;
`endif

    logic [STATE_W-1:0] state;
    logic [BYTE_W-1:0]  cnt_hi;
    logic [CNT_W-1:0]   words_left;
    logic [CNT_W-1:0]   cnt_full;
    logic [WORD_W-1:0]  addr;
    logic [WORD_W-1:0]  wdata;
    logic [WORD_W-1:0]  asm_word;
    logic               asm_done;
    logic               accept;
    logic               start;
    logic               byte_en;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  chk_x;
`endif

    assign accept   = in_valid && in_ready;
    assign start    = accept && (in_data == HDR_BYTE) && ((state == ST_IDLE) || (state == ST_DONE));
    assign byte_en  = accept && (state == ST_DATA);
    assign cnt_full = {cnt_hi, in_data};

    imem_loader_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .byte_en   (byte_en),
        .byte_in   (in_data),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt_hi     <= '0;
            words_left <= '0;
            addr       <= '0;
            wdata      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_x      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_CNT_HI;
                        addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_x <= '0;
`endif
                    end
                end
                ST_CNT_HI: begin
                    if (accept) begin
                        cnt_hi <= in_data;
                        state  <= ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (accept) begin
                        words_left <= cnt_full;
                        // Oversized frames are rejected before any word can land past IM_DEPTH.
                        if (cnt_full == '0)
                            state <= ST_DONE;
                        else if (WORD_W'(cnt_full) > IM_DEPTH)
                            state <= ST_ERR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_x <= chk_x ^ in_data;
`endif
                        if (asm_done) begin
                            wdata <= asm_word;
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    addr       <= next_addr(addr);
                    words_left <= words_left - CNT_W'(1);
                    state      <= (words_left == CNT_W'(1)) ? ST_AFTER_DATA : ST_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept)
                        state <= (in_data == chk_x) ? ST_DONE : ST_ERR;
                end
`endif
                default: state <= state;
            endcase
        end
    end

    // im_we is masked by rst so a write pending in the reset cycle never reaches memory.
    assign in_ready = (state != ST_WRITE) && (state != ST_ERR);
    assign im_we    = (state == ST_WRITE) && !rst;
    assign im_addr  = addr;
    assign im_wdata = wdata;
    assign cpu_hold = (state != ST_DONE);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IM_DEPTH, default 256, instruction-memory depth in 32-bit words.
REQ-002 Parameter HDR_BYTE, default 8'hA5, frame start byte.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  byte stream payload.
REQ-006 in_valid  input  1  in_data valid; byte accepted when in_valid && in_ready.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 im_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 im_addr  output  32  byte address of the write, word-aligned, PC-compatible.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  holds CPU program counter at 0 while high.
REQ-012 done  output  1  load completed successfully; CPU released.
REQ-013 error  output  1  malformed or oversized frame.

Function
REQ-014 Frame SHALL be: HDR_BYTE, count high byte, count low byte, count*4 data bytes, each word big-endian (first byte = bits 31:24).
REQ-015 States SHALL be IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERR (plus CHK when configured).
REQ-016 IDLE: accepted byte == HDR_BYTE -> CNT_HI; other bytes are discarded, state unchanged.
REQ-017 CNT_HI -> CNT_LO -> DATA on accepted bytes; count == 0 -> DONE directly; count > IM_DEPTH -> ERR.
REQ-018 DATA: fourth accepted byte of a word -> WRITE; WRITE lasts exactly one cycle with im_we=1 and in_ready=0, then DATA, or DONE after the last word.
REQ-019 im_addr SHALL start at 0 per frame and increment by 4 after every write; words beyond IM_DEPTH are never written.
REQ-020 in_ready SHALL be 1 in all states except WRITE and ERR.
REQ-021 cpu_hold SHALL be 1 from reset and from any accepted HDR_BYTE until DONE is entered; 0 in DONE.
REQ-022 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-023 In DONE an accepted HDR_BYTE SHALL restart loading (-> CNT_HI, cpu_hold=1, done=0); other bytes are ignored.
REQ-024 ERR SHALL persist, with cpu_hold=1, until reset.
REQ-025 in_valid low in any state SHALL stall without changing state, partial word or address.

Reset
REQ-026 On rst: state IDLE, cpu_hold=1, in_ready=1, im_we=0, im_addr=0, im_wdata=0, done=0, error=0, partial word and byte index cleared.
REQ-027 rst asserted mid-frame SHALL abandon the frame; no im_we in the reset cycle or after it until a new frame.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN: when defined, a trailer byte follows the data (state CHK); XOR of all data bytes must equal it -> DONE, else -> ERR.
REQ-029 Without the macro, DONE SHALL be entered right after the last WRITE and no trailer is expected.

Structure
REQ-030 Shared package imem_loader_pkg SHALL hold the state enumeration, default HDR_BYTE and frame-field widths.
REQ-031 One sub-module, imem_loader_asm, SHALL shift bytes into a 32-bit word and flag completion of a word.

Verification
REQ-032 Frame A5 00 02 20 08 00 05 20 09 00 07 -> writes 20080005 @0, 20090007 @4, then done=1, cpu_hold=0.
REQ-033 Bytes 00 FF then A5 00 00 -> first two ignored, no im_we, done=1.
REQ-034 Count 0x0101 with IM_DEPTH=256 -> error=1, cpu_hold=1, no im_we; cleared only by rst.
REQ-035 rst pulsed after 6 data bytes, then a full 1-word frame -> single write at address 0, done=1.
REQ-036 With IMEM_LOADER_CHECKSUM_EN, 1-word frame 01 02 03 04 with trailer 04 -> done=1; trailer 05 -> error=1.
REQ-037 in_valid toggled randomly across a 3-word frame -> same three writes at 0, 4, 8 as with continuous valid.
